// File: rtl/wb_slot_arbiter.sv
// -----------------------------------------------------------------------------
// wb_slot_arbiter
//   Time-division arbiter that lets NUM_WBC pipelined Wishbone controllers and
//   the CPU share one Wishbone bus. A slot counter advances on every
//   clk8_en_i pulse. SLOT_MAP names the owner of each slot. At most one
//   single-beat transaction is issued per slot, and an issue/ack FSM tracks it.
//
//   Optional feature (compile-time macro WB_SLOT_RECLAIM_EN):
//     defined   - a controller slot whose owner has no CYC&STB at slot start is
//                 donated to the lowest-index requesting controller.
//     undefined - an unused controller slot stays idle.
//
// Ports
//   wb_clock_i, wb_reset_i      clock, synchronous active-high reset
//   clk8_en_i                   slot advance pulse
//   wbc_*                       per-controller Wishbone slave side
//                               (controller k at slice k)
//   wb_*                        shared Wishbone master side
//   cpu_grant_en_o              pulse at the start of each run of CPU slots
//   overrun_o                   pulse when a slot starts while a transaction
//                               is still open
// -----------------------------------------------------------------------------
module wb_slot_arbiter #(
    parameter int NUM_WBC       = 2,
    parameter int SLOT_BITS     = 3,
    parameter int OWNER_W       = 2,
    parameter logic [(OWNER_W<<SLOT_BITS)-1:0] SLOT_MAP = 16'h5F00,
    parameter int WB_ADDR_WIDTH = 16,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                             wb_clock_i,
    input  logic                             wb_reset_i,
    input  logic                             clk8_en_i,
    input  logic [NUM_WBC*WB_ADDR_WIDTH-1:0] wbc_addr_i,
    input  logic [NUM_WBC*DATA_WIDTH-1:0]    wbc_dout_i,
    output logic [NUM_WBC*DATA_WIDTH-1:0]    wbc_din_o,
    input  logic [NUM_WBC-1:0]               wbc_we_i,
    input  logic [NUM_WBC-1:0]               wbc_cycle_i,
    input  logic [NUM_WBC-1:0]               wbc_strobe_i,
    output logic [NUM_WBC-1:0]               wbc_stall_o,
    output logic [NUM_WBC-1:0]               wbc_ack_o,
    output logic [WB_ADDR_WIDTH-1:0]         wb_addr_o,
    output logic [DATA_WIDTH-1:0]            wb_dout_o,
    output logic                             wb_we_o,
    output logic                             wb_cycle_o,
    output logic                             wb_strobe_o,
    input  logic [DATA_WIDTH-1:0]            wb_din_i,
    input  logic                             wb_stall_i,
    input  logic                             wb_ack_i,
    output logic                             cpu_grant_en_o,
    output logic                             overrun_o
);

    localparam int NSLOT = 1 << SLOT_BITS;
    localparam logic [OWNER_W-1:0] CPU_CODE = '1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_ACK} state_t;

    state_t               state_q, state_d;
    logic [SLOT_BITS-1:0] slot_q, slot_d;
    logic                 start_q, start_d;
    logic [OWNER_W-1:0]   owner_q, owner_d;
    // Controller of the open transaction; kept apart from owner_q so that a
    // slot start during an overrun cannot move the bus mux mid-transaction.
    logic [OWNER_W-1:0]   gnt_q, gnt_d;

    logic [NUM_WBC-1:0]   req;
    logic [SLOT_BITS-1:0] prev_slot;
    logic [OWNER_W-1:0]   slot_owner, prev_owner;
    logic                 slot_is_wbc, own_req;
`ifdef WB_SLOT_RECLAIM_EN
    logic                 donee_found;
    logic [OWNER_W-1:0]   donee;
`endif

    function automatic logic [OWNER_W-1:0] map_owner(input logic [SLOT_BITS-1:0] s);
        logic [OWNER_W-1:0] o;
        o = '0;
        for (int i = 0; i < NSLOT; i++)
            if (s == SLOT_BITS'(i)) o = SLOT_MAP[i*OWNER_W +: OWNER_W];
        return o;
    endfunction

    assign req        = wbc_cycle_i & wbc_strobe_i;
    assign prev_slot  = slot_q - SLOT_BITS'(1);
    assign slot_owner = map_owner(slot_q);
    assign prev_owner = map_owner(prev_slot);
    // Codes at or above NUM_WBC that are not the CPU code mark idle slots.
    assign slot_is_wbc = (slot_owner != CPU_CODE) && (int'(slot_owner) < NUM_WBC);
    assign wbc_din_o   = {NUM_WBC{wb_din_i}};

    always_comb begin
        own_req = 1'b0;
        for (int k = 0; k < NUM_WBC; k++)
            if (slot_owner == OWNER_W'(k)) own_req = req[k];
    end

`ifdef WB_SLOT_RECLAIM_EN
    always_comb begin
        donee_found = 1'b0;
        donee       = '0;
        for (int k = 0; k < NUM_WBC; k++) begin
            if (!donee_found && req[k] && slot_owner != OWNER_W'(k)) begin
                donee_found = 1'b1;
                donee       = OWNER_W'(k);
            end
        end
    end
`endif

    // Slot bookkeeping and the issue/ack FSM.
    always_comb begin
        slot_d         = clk8_en_i ? slot_q + SLOT_BITS'(1) : slot_q;
        start_d        = clk8_en_i;
        owner_d        = owner_q;
        gnt_d          = gnt_q;
        state_d        = state_q;
        cpu_grant_en_o = 1'b0;
        overrun_o      = 1'b0;
        wb_cycle_o     = 1'b0;
        wb_strobe_o    = 1'b0;

        if (start_q) begin
            owner_d        = slot_owner;
            cpu_grant_en_o = (slot_owner == CPU_CODE) && (prev_owner != CPU_CODE);
            overrun_o      = (state_q != S_IDLE);
        end

        case (state_q)
            S_IDLE: begin
                // A start that lands during an open transaction is simply lost:
                // only a start seen from IDLE may issue.
                if (start_q && slot_is_wbc) begin
                    if (own_req) begin
                        gnt_d   = slot_owner;
                        state_d = S_ISSUE;
                    end
`ifdef WB_SLOT_RECLAIM_EN
                    else if (donee_found) begin
                        gnt_d   = donee;
                        owner_d = donee;
                        state_d = S_ISSUE;
                    end
`endif
                end
            end
            S_ISSUE: begin
                wb_cycle_o  = 1'b1;
                wb_strobe_o = 1'b1;
                if (!wb_stall_i) state_d = wb_ack_i ? S_IDLE : S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                wb_cycle_o = 1'b1;
                if (wb_ack_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bus mux and per-controller handshake returns.
    always_comb begin
        wb_addr_o   = '0;
        wb_dout_o   = '0;
        wb_we_o     = 1'b0;
        wbc_stall_o = '1;
        wbc_ack_o   = '0;
        for (int k = 0; k < NUM_WBC; k++) begin
            if (gnt_q == OWNER_W'(k)) begin
                wb_addr_o = wbc_addr_i[k*WB_ADDR_WIDTH +: WB_ADDR_WIDTH];
                wb_dout_o = wbc_dout_i[k*DATA_WIDTH +: DATA_WIDTH];
                wb_we_o   = wbc_we_i[k];
                if (state_q == S_ISSUE) wbc_stall_o[k] = wb_stall_i;
                // An ack arriving together with acceptance is forwarded too.
                wbc_ack_o[k] = wb_ack_i &&
                               ((state_q == S_WAIT_ACK) || (state_q == S_ISSUE && !wb_stall_i));
            end
        end
    end

    always_ff @(posedge wb_clock_i) begin
        if (wb_reset_i) begin
            state_q <= S_IDLE;
            slot_q  <= '1;
            start_q <= 1'b0;
            owner_q <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            start_q <= start_d;
            owner_q <= owner_d;
            gnt_q   <= gnt_d;
        end
    end

endmodule

// File: tb/tb_wb_slot_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_slot_arbiter
//   Scoreboard bench for wb_slot_arbiter (default parameters, 8 slots:
//   0-3 wbc0, 4-5 CPU, 6-7 wbc1). The stimulus process plays both the
//   controllers and the bus slave. At each slot start it decides from the slot
//   table which request should win, and it pushes the expected bus transaction
//   into a queue. A negedge monitor pops that queue on every bus acceptance.
//   The monitor also checks the per-cycle handshake expectations.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wb_slot_arbiter;
    localparam int N  = 2;
    localparam int AW = 16;
    localparam int DW = 8;
    localparam int CPU = 3;

    logic          clk = 1'b0, rst = 1'b1, clk8 = 1'b0;
    logic [N*AW-1:0] wbc_addr = '0;
    logic [N*DW-1:0] wbc_dout = '0;
    logic [N*DW-1:0] wbc_din;
    logic [N-1:0]  wbc_we = '0, wbc_cyc = '0, wbc_stb = '0;
    logic [N-1:0]  wbc_stall, wbc_ack;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_dout;
    logic [DW-1:0] wb_din = '0;
    logic          wb_we, wb_cyc, wb_stb;
    logic          wb_stall = 1'b1, wb_ack = 1'b0;
    logic          cpu_gnt, ovr;

    wb_slot_arbiter dut (
        .wb_clock_i(clk), .wb_reset_i(rst), .clk8_en_i(clk8),
        .wbc_addr_i(wbc_addr), .wbc_dout_i(wbc_dout), .wbc_din_o(wbc_din),
        .wbc_we_i(wbc_we), .wbc_cycle_i(wbc_cyc), .wbc_strobe_i(wbc_stb),
        .wbc_stall_o(wbc_stall), .wbc_ack_o(wbc_ack),
        .wb_addr_o(wb_addr), .wb_dout_o(wb_dout), .wb_we_o(wb_we),
        .wb_cycle_o(wb_cyc), .wb_strobe_o(wb_stb),
        .wb_din_i(wb_din), .wb_stall_i(wb_stall), .wb_ack_i(wb_ack),
        .cpu_grant_en_o(cpu_gnt), .overrun_o(ovr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            k;
        logic [AW-1:0] addr;
        logic [DW-1:0] dat;
        logic          we;
    } txn_t;

    txn_t exp_q[$];
    int   n_cmp = 0, n_bad = 0;

    // Controller side: one outstanding request per controller, held until acked.
    bit            req_v[N];
    logic [AW-1:0] req_a[N];
    logic [DW-1:0] req_d[N];
    bit            req_w[N];

    // Model of the shared bus: slot number and the one open transaction.
    int slot_m = 7;
    bit start_pend = 0, busy = 0, acc = 0;
    int cur_k = 0, st_left = 0, ack_left = 0;

    // Knobs: -1 means random.
    int stall_cfg = -1, ack_cfg = -1, din_cfg = -1;
    bit rnd_req = 0;

    // Per-cycle expectations handed to the monitor.
    bit           mon_en = 0;
    bit           e_cyc = 0, e_stb = 0, e_ovr = 0, e_cpu = 0;
    logic [N-1:0] e_stall = '1, e_ack = '0;

    function automatic int owner_of(input int s);
        if (s < 4) return 0;
        if (s < 6) return CPU;
        return 1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic raise(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit w);
        req_v[k] = 1'b1; req_a[k] = a; req_d[k] = d; req_w[k] = w;
    endtask

    // One clock cycle of stimulus plus the model's view of it.
    task automatic step(input bit en, input bit r = 1'b0);
        bit b0, a0, is_start, ack_now, stray, stall_v;
        int o, g;
        @(posedge clk); #1;
        b0 = busy; a0 = acc; ack_now = 0; stray = 0; stall_v = 1;
        is_start   = start_pend;
        start_pend = en && !r;
        if (is_start) slot_m = (slot_m + 1) % 8;

        if (rnd_req && !r)
            for (int k = 0; k < N; k++)
                if (!req_v[k] && $urandom_range(0, 3) == 0)
                    raise(k, AW'($urandom), DW'($urandom), 1'($urandom_range(0, 1)));

        // Bus slave: stall for st_left strobe cycles, ack ack_left cycles after.
        if (b0 && !a0 && !r) begin
            if (st_left > 0) st_left--;
            else begin
                stall_v = 0; acc = 1;
                if (ack_left == 0) ack_now = 1;
            end
        end else if (b0 && a0 && !r) begin
            ack_left--;
            if (ack_left == 0) ack_now = 1;
        end else if (!r && rnd_req) begin
            stall_v = 1'($urandom_range(0, 1));
            stray   = ($urandom_range(0, 7) == 0) && !b0;
        end

        e_cyc   = b0;
        e_stb   = b0 && !a0;
        e_stall = '1;
        if (b0 && !a0) e_stall[cur_k] = stall_v;
        e_ack = '0;
        if (ack_now) e_ack[cur_k] = 1'b1;

        e_ovr = 0; e_cpu = 0;
        if (is_start) begin
            o     = owner_of(slot_m);
            e_cpu = (o == CPU) && (owner_of((slot_m + 7) % 8) != CPU);
            e_ovr = b0;
            if (!b0 && !r && o < N) begin
                g = -1;
                if (req_v[o]) g = o;
`ifdef WB_SLOT_RECLAIM_EN
                else for (int j = 0; j < N; j++) if (g < 0 && req_v[j]) g = j;
`endif
                if (g >= 0) begin
                    exp_q.push_back('{g, req_a[g], req_d[g], req_w[g]});
                    busy = 1; acc = 0; cur_k = g;
                    st_left  = (stall_cfg < 0) ? int'($urandom_range(0, 2)) : stall_cfg;
                    ack_left = (ack_cfg < 0)   ? int'($urandom_range(0, 3)) : ack_cfg;
                end
            end
        end

        rst      = r;
        clk8     = en;
        wb_stall = stall_v;
        wb_ack   = ack_now | stray;
        wb_din   = (din_cfg >= 0) ? DW'(din_cfg) : DW'($urandom);
        for (int k = 0; k < N; k++) begin
            wbc_cyc[k] = req_v[k];
            wbc_stb[k] = req_v[k];
            wbc_we[k]  = req_w[k];
            wbc_addr[k*AW +: AW] = req_a[k];
            wbc_dout[k*DW +: DW] = req_d[k];
        end

        if (ack_now) begin busy = 0; acc = 0; req_v[cur_k] = 0; end
        if (r) begin
            if (busy && !acc && exp_q.size() > 0) void'(exp_q.pop_back());
            busy = 0; acc = 0; slot_m = 7; start_pend = 0;
            for (int k = 0; k < N; k++) req_v[k] = 0;
        end
    endtask

    // per == 0 picks a random slot length.
    task automatic run_slots(input int n, input int per);
        int p;
        for (int s = 0; s < n; s++) begin
            p = (per == 0) ? int'($urandom_range(2, 6)) : per;
            step(1'b1);
            for (int c = 1; c < p; c++) step(1'b0);
        end
    endtask

    // Monitor: per-cycle handshake checks and scoreboard pop on acceptance.
    always @(negedge clk) begin
        txn_t t;
        if (mon_en) begin
            chk("wb_cycle_o", 64'(wb_cyc), 64'(e_cyc));
            chk("wb_strobe_o", 64'(wb_stb), 64'(e_stb));
            chk("overrun_o", 64'(ovr), 64'(e_ovr));
            chk("cpu_grant_en_o", 64'(cpu_gnt), 64'(e_cpu));
            chk("wbc_stall_o", 64'(wbc_stall), 64'(e_stall));
            chk("wbc_ack_o", 64'(wbc_ack), 64'(e_ack));
            if (|e_ack) chk("wbc_din_o", 64'(wbc_din), 64'({N{wb_din}}));
            if (wb_stb && !wb_stall) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL txn: unexpected bus accept addr %0h, none expected", wb_addr);
                end else begin
                    t = exp_q.pop_front();
                    chk("wb_addr_o", 64'(wb_addr), 64'(t.addr));
                    chk("wb_dout_o", 64'(wb_dout), 64'(t.dat));
                    chk("wb_we_o", 64'(wb_we), 64'(t.we));
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < N; k++) begin
            req_v[k] = 0; req_a[k] = '0; req_d[k] = '0; req_w[k] = 0;
        end
        // Reset: outputs idle, stalls all ones.
        step(1'b0, 1'b1);
        mon_en = 1;
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);

        // A full frame and one more slot with no requests.
        run_slots(9, 3);

        // wbc0 read at 'h8000: two stalled strobe cycles, ack one cycle later.
        step(1'b0, 1'b1);
        raise(0, 16'h8000, 8'h00, 1'b0);
        stall_cfg = 2; ack_cfg = 1; din_cfg = 8'h5A;
        run_slots(2, 8);

        // wbc1 write raised during slot 2 waits for wbc1's slot.
        stall_cfg = 0; din_cfg = -1;
        run_slots(1, 4);
        raise(1, 16'h1234, 8'h42, 1'b1);
        run_slots(5, 4);

        // A long ack overruns the next slot, and wbc0's held request is not reissued.
        raise(0, 16'h00C3, 8'h11, 1'b1);
        ack_cfg = 6;
        run_slots(3, 4);

        // Reset while waiting for an ack, then the slot numbering restarts at 0.
        raise(0, 16'h0F0F, 8'h22, 1'b0);
        ack_cfg = 10;
        run_slots(1, 4);
        step(1'b0, 1'b1);
        raise(0, 16'hBEEF, 8'h33, 1'b1);
        ack_cfg = 2;
        run_slots(2, 4);

        // Random traffic with random slot lengths, stalls and ack delays.
        stall_cfg = -1; ack_cfg = -1; rnd_req = 1;
        run_slots(300, 0);
        rnd_req = 0;
        run_slots(20, 8);
        chk("scoreboard drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
